// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle for the forwarding/hazard unit: D/E/M/W register fields in,
// ALU operand selects, stall/flush controls and multiply-scoreboard status out.
interface fwd_hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] rs_addrD;
    logic [REG_ADDR_W-1:0] rt_addrD;
    logic                  uses_rsD;
    logic                  uses_rtD;
    logic                  reg_writeD;
    logic [REG_ADDR_W-1:0] write_reg_addrD;
    logic                  is_mulD;

    logic [REG_ADDR_W-1:0] rs_addrE;
    logic [REG_ADDR_W-1:0] rt_addrE;
    logic                  mem_readE;
    logic                  reg_writeE;
    logic [REG_ADDR_W-1:0] write_reg_addrE;
    logic                  mul_issueE;

    logic                  reg_writeM;
    logic [REG_ADDR_W-1:0] write_reg_addrM;
    logic                  reg_writeW;
    logic [REG_ADDR_W-1:0] write_reg_addrW;

    logic [1:0]            fw_alu1;
    logic [1:0]            fw_alu2;
    logic                  stallF;
    logic                  stallD;
    logic                  flushE;
    logic                  mul_busy;
    logic                  mul_done;
    logic [REG_ADDR_W-1:0] mul_dest;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output rs_addrD, rt_addrD, uses_rsD, uses_rtD, reg_writeD, write_reg_addrD, is_mulD,
        output rs_addrE, rt_addrE, mem_readE, reg_writeE, write_reg_addrE, mul_issueE,
        output reg_writeM, write_reg_addrM, reg_writeW, write_reg_addrW,
        input  fw_alu1, fw_alu2, stallF, stallD, flushE,
        input  mul_busy, mul_done, mul_dest, stall_count
    );

    modport slave (
        input  rs_addrD, rt_addrD, uses_rsD, uses_rtD, reg_writeD, write_reg_addrD, is_mulD,
        input  rs_addrE, rt_addrE, mem_readE, reg_writeE, write_reg_addrE, mul_issueE,
        input  reg_writeM, write_reg_addrM, reg_writeW, write_reg_addrW,
        output fw_alu1, fw_alu2, stallF, stallD, flushE,
        output mul_busy, mul_done, mul_dest, stall_count
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding, load-use / multiply hazard detection and a single-entry
// countdown scoreboard for one outstanding multi-cycle multiply.
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int MUL_LAT    = 4,
    parameter bit FWD_W_EN   = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    fwd_hazard_unit_if.slave hz
);
    localparam int CNT_BITS = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MUL_LAT - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_W-1:0]    STALL_ONE = CNT_W'(1);

    typedef logic [REG_ADDR_W-1:0] regAddr_t;
    typedef enum logic {MUL_IDLE = 1'b0, MUL_BUSY = 1'b1} mulState_t;

    mulState_t           mulState;
    mulState_t           mulStateNext;
    logic [CNT_BITS-1:0] mulCnt;
    logic [CNT_BITS-1:0] mulCntNext;
    regAddr_t            mulDest;
    regAddr_t            mulDestNext;
    logic [CNT_W-1:0]    stallCount;

    logic       busy;
    logic       mulDone;
    logic       mulFar;
    logic       issueOk;
    logic       loadUse;
    logic       mulRaw;
    logic       mulWaw;
    logic       mulStruct;
    logic       stallAny;
    logic [1:0] fwd1;
    logic [1:0] fwd2;

    // $0 is hardwired, so it never produces a dependency.
    function automatic logic regMatch(input regAddr_t a, input regAddr_t b);
        return (a != '0) && (a == b);
    endfunction

    function automatic logic [1:0] fwdSel(
        input regAddr_t src,
        input logic     done,
        input regAddr_t dest,
        input logic     wrM,
        input regAddr_t addrM,
        input logic     wrW,
        input regAddr_t addrW
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (done && regMatch(src, dest)) begin
            sel = 2'b11;
        end else if (wrM && regMatch(src, addrM)) begin
            sel = 2'b10;
        end else if (FWD_W_EN && wrW && regMatch(src, addrW)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign busy    = (mulState == MUL_BUSY);
    assign mulDone = busy && (mulCnt == '0);
    assign mulFar  = busy && (32'(mulCnt) >= 32'd2);
    assign issueOk = hz.mul_issueE && (!busy || mulDone);

    always_ff @(posedge clk) begin
        if (rst) begin
            mulState   <= MUL_IDLE;
            mulCnt     <= '0;
            mulDest    <= '0;
            stallCount <= '0;
        end else begin
            mulState <= mulStateNext;
            mulCnt   <= mulCntNext;
            mulDest  <= mulDestNext;
            if (stallAny && (stallCount != '1)) begin
                stallCount <= stallCount + STALL_ONE;
            end
        end
    end

    // Issue in the done cycle takes precedence over retiring the previous multiply.
    always_comb begin
        mulStateNext = mulState;
        mulCntNext   = mulCnt;
        mulDestNext  = mulDest;
        if (issueOk) begin
            mulStateNext = MUL_BUSY;
            mulCntNext   = CNT_LOAD;
            mulDestNext  = hz.write_reg_addrE;
        end else if (mulDone) begin
            mulStateNext = MUL_IDLE;
        end else if (busy) begin
            mulCntNext = mulCnt - CNT_ONE;
        end
    end

    always_comb begin
        loadUse = hz.mem_readE && hz.reg_writeE &&
                  ((hz.uses_rsD && regMatch(hz.rs_addrD, hz.write_reg_addrE)) ||
                   (hz.uses_rtD && regMatch(hz.rt_addrD, hz.write_reg_addrE)));
        mulRaw  = mulFar &&
                  ((hz.uses_rsD && regMatch(hz.rs_addrD, mulDest)) ||
                   (hz.uses_rtD && regMatch(hz.rt_addrD, mulDest)));
        mulWaw  = mulFar && hz.reg_writeD && regMatch(hz.write_reg_addrD, mulDest);
        mulStruct = mulFar && hz.is_mulD;
        stallAny  = loadUse || mulRaw || mulWaw || mulStruct;
    end

    always_comb begin
        fwd1 = fwdSel(hz.rs_addrE, mulDone, mulDest, hz.reg_writeM, hz.write_reg_addrM,
                      hz.reg_writeW, hz.write_reg_addrW);
        fwd2 = fwdSel(hz.rt_addrE, mulDone, mulDest, hz.reg_writeM, hz.write_reg_addrM,
                      hz.reg_writeW, hz.write_reg_addrW);
    end

    // Everything visible reads zero while reset is held, even before the clearing edge.
    assign hz.fw_alu1     = rst ? 2'b00 : fwd1;
    assign hz.fw_alu2     = rst ? 2'b00 : fwd2;
    assign hz.stallF      = !rst && stallAny;
    assign hz.stallD      = !rst && stallAny;
    assign hz.flushE      = !rst && stallAny;
    assign hz.mul_busy    = !rst && busy;
    assign hz.mul_done    = !rst && mulDone;
    assign hz.mul_dest    = rst ? '0 : mulDest;
    assign hz.stall_count = rst ? '0 : stallCount;
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor of the EX-stage forwarding unit for the 5-stage MIPS pipeline.
- Generates the ALU operand forwarding selects, detects load-use hazards, and tracks one outstanding multi-cycle multiply with a countdown scoreboard.
- Drives F/D stall and E flush. Counts stall cycles for performance monitoring.
- Sits beside the hazard path, between the decode/execute pipeline registers and the ALU operand muxes.

Parameters:
- REG_ADDR_W, 5: register address width.
- MUL_LAT, 4: multiply latency in cycles from issue in E to result ready; legal range >=1.
- FWD_W_EN, 1: 1 enables forwarding from W; 0 disables it (register file is write-before-read).
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- rs_addrD, rt_addrD  in  REG_ADDR_W  D-stage source registers.
- uses_rsD, uses_rtD  in  1  D instruction actually reads rs/rt.
- reg_writeD  in  1  D instruction writes a register.
- write_reg_addrD  in  REG_ADDR_W  D destination.
- is_mulD  in  1  D instruction is a multiply.
- rs_addrE, rt_addrE  in  REG_ADDR_W  E-stage source registers.
- mem_readE, reg_writeE  in  1  E instruction is a load / writes a register.
- write_reg_addrE  in  REG_ADDR_W  E destination.
- mul_issueE  in  1  E instruction issues a multiply this cycle.
- reg_writeM  in  1  M write enable.
- write_reg_addrM  in  REG_ADDR_W  M destination.
- reg_writeW  in  1  W write enable.
- write_reg_addrW  in  REG_ADDR_W  W destination.
- fw_alu1, fw_alu2  out  2  operand selects: 00 none, 10 M, 01 W, 11 multiply result.
- stallF, stallD, flushE  out  1  pipeline control.
- mul_busy  out  1  a multiply is outstanding.
- mul_done  out  1  multiply result valid this cycle.
- mul_dest  out  REG_ADDR_W  pending multiply destination.
- stall_count  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- State: busy, cnt (range 0..MUL_LAT-1), mul_dest, stall_count.
- Reset: all state cleared to 0. While rst=1, all outputs read 0. A pending multiply is abandoned and produces no mul_done.
- Register 0 never matches any comparison, in any stage.
- mul_busy = busy.
- mul_done = busy && cnt==0.
- mul_far = busy && cnt>=2.
- Issue: at a clock edge with mul_issueE=1 and (!busy or mul_done):
  - busy<=1, cnt<=MUL_LAT-1, mul_dest<=write_reg_addrE.
  - Back-to-back issue during the done cycle is legal.
- Issue while busy && !mul_done is a protocol violation and is ignored.
- Completion: in the mul_done cycle with no new issue, busy<=0 at the next edge. Otherwise, with busy=1, cnt decrements by 1 each cycle.
- The multiply result is written to the register file at the edge that ends the mul_done cycle.
- Forwarding is combinational. Priority per operand (fw_alu1 uses rs_addrE, fw_alu2 uses rt_addrE):
  - 11 if mul_done && mul_dest==src.
  - else 10 if reg_writeM && write_reg_addrM==src.
  - else 01 if FWD_W_EN && reg_writeW && write_reg_addrW==src.
  - else 00.
- Stall conditions (combinational, OR-ed):
  - Load-use: mem_readE && reg_writeE && ((uses_rsD && rs_addrD==write_reg_addrE) || (uses_rtD && rt_addrD==write_reg_addrE)).
  - Multiply RAW: mul_far && (uses_rsD && rs_addrD==mul_dest || uses_rtD && rt_addrD==mul_dest).
  - Multiply WAW: mul_far && reg_writeD && write_reg_addrD==mul_dest.
  - Structural: mul_far && is_mulD.
- Outputs: stallF = stallD = flushE = OR of the stall conditions. No latency: asserted in the same cycle the condition holds.
- A load-use stall lasts exactly 1 cycle.
- Multiply stalls release when cnt reaches 1, so the consumer enters E in the done cycle and gets select 11.
- stall_count: increments at each edge where stallD=1 and rst=0. It saturates at all-ones.
- Simultaneous events:
  - Issue and done in the same cycle: the new operation wins. mul_dest updates and busy stays 1.
  - Load-use and multiply stall together: a single stall.

Test Plan:
1. Forward priority: reg_writeM=1, addrM=3, reg_writeW=1, addrW=3, rs_addrE=3 -> fw_alu1=10. Then set addrM=4 -> fw_alu1=01. Then FWD_W_EN=0 build -> 00. Set rs_addrE=0 with addrM=0 -> 00.
2. Load-use: mem_readE=1, reg_writeE=1, write_reg_addrE=8, uses_rtD=1, rt_addrD=8 -> stallF/stallD/flushE=1 for 1 cycle, stall_count 0->1. Repeat with uses_rtD=0 -> no stall.
3. Multiply RAW, MUL_LAT=4: issue with dest 9. D reads $9 -> stall 2 cycles (cnt 3, 2). Consumer enters E in the cycle with cnt=0 -> mul_done=1, fw_alu1=11. Then busy=0.
4. Back-to-back multiply: second is_mulD behind first -> stalls while cnt>=2. Issues in the done cycle -> busy stays 1, mul_dest updates, cnt=3.
5. WAW and priority: D writes $9 while mul_far -> stall. At mul_done with reg_writeM=1, addrM=9, rs_addrE=9 -> fw_alu1=11 (multiply wins).
6. Reset mid-operation: rst=1 while cnt=2 -> next cycle busy=0, no mul_done, stall_count=0, all outputs 0. Counter saturation: force CNT_W=2, stall 5 cycles -> stall_count=3.
